// File: rtl/spi_pkg.sv
// Shared types and constants for the quad-SPI arbiter and its round-robin picker.
package spi_pkg;

  typedef enum logic [1:0] {
    FLASH    = 2'd0,
    RAM_A    = 2'd1,
    RAM_B    = 2'd2,
    RESERVED = 2'd3
  } spi_target_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } spi_arb_state_e;

  localparam int TIMEOUT_CYCLES = 1023;

  // Flash is read-only from this port and the reserved target selects nothing.
  function automatic logic is_illegal(input logic write, input logic [1:0] target);
    return (write && (spi_target_e'(target) == FLASH)) || (spi_target_e'(target) == RESERVED);
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one quad-SPI engine between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [2*NUM_REQ-1:0]                req_target,
  input  logic [ADDRESS_WIDTH*NUM_REQ-1:0]    req_addr,
  input  logic [DATA_BUS_WIDTH*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic                                req_error,
  output logic [DATA_BUS_WIDTH-1:0]           rdata,
  output logic                                eng_start,
  output logic                                eng_write,
  output logic [1:0]                          eng_target,
  output logic [ADDRESS_WIDTH-1:0]            eng_addr,
  output logic [DATA_BUS_WIDTH-1:0]           eng_wdata,
  input  logic                                eng_done,
  input  logic [DATA_BUS_WIDTH-1:0]           eng_rdata,
  output logic                                busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  spi_arb_state_e            state;
  logic [IDX_W-1:0]          ptr;
  logic [IDX_W-1:0]          owner;
  logic                      rejected;
  logic [NUM_REQ-1:0]        pick_onehot;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;
  logic                      sel_write;
  logic [1:0]                sel_target;
  logic [ADDRESS_WIDTH-1:0]  sel_addr;
  logic [DATA_BUS_WIDTH-1:0] sel_wdata;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [9:0]                wdog;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_write  = 1'b0;
    sel_target = 2'd0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_write  = req_write[i];
        sel_target = req_target[2*i +: 2];
        sel_addr   = req_addr[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
        sel_wdata  = req_wdata[DATA_BUS_WIDTH*i +: DATA_BUS_WIDTH];
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      rejected   <= 1'b0;
      req_grant  <= '0;
      req_done   <= '0;
      req_error  <= 1'b0;
      rdata      <= '0;
      eng_start  <= 1'b0;
      eng_write  <= 1'b0;
      eng_target <= 2'd0;
      eng_addr   <= '0;
      eng_wdata  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      req_done  <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            req_grant <= pick_onehot;
            state     <= ISSUE;
            // Illegal requests never load the engine bus or pulse eng_start.
            if (is_illegal(sel_write, sel_target)) begin
              rejected <= 1'b1;
            end else begin
              rejected   <= 1'b0;
              eng_start  <= 1'b1;
              eng_write  <= sel_write;
              eng_target <= sel_target;
              eng_addr   <= sel_addr;
              eng_wdata  <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          if (rejected) begin
            req_done  <= req_grant;
            req_error <= 1'b1;
            state     <= RESP;
          end else begin
            state <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog  <= '0;
`endif
          end
        end
        WAIT: begin
          if (eng_done) begin
            rdata     <= eng_rdata;
            req_error <= 1'b0;
            req_done  <= req_grant;
            state     <= RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wdog == 10'(TIMEOUT_CYCLES - 1)) begin
            rdata     <= '1;
            req_error <= 1'b1;
            req_done  <= req_grant;
            state     <= RESP;
          end else begin
            wdog <= wdog + 10'd1;
          end
`endif
        end
        RESP: begin
          state      <= IDLE;
          req_grant  <= '0;
          req_error  <= 1'b0;
          rejected   <= 1'b0;
          ptr        <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          eng_write  <= 1'b0;
          eng_target <= 2'd0;
          eng_addr   <= '0;
          eng_wdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: reset, reads/writes, round-robin order, illegal ops,
// stray eng_done, reset mid-transfer and the SPI_ARB_TIMEOUT_EN watchdog (either build).
module tb_spi_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [5:0]  req_target;
  logic [47:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_grant;
  logic [2:0]  req_done;
  logic        req_error;
  logic [7:0]  rdata;
  logic        eng_start;
  logic        eng_write;
  logic [1:0]  eng_target;
  logic [15:0] eng_addr;
  logic [7:0]  eng_wdata;
  logic        eng_done;
  logic [7:0]  eng_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int base;

  spi_arbiter #(.NUM_REQ(3), .ADDRESS_WIDTH(16), .DATA_BUS_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_target (req_target),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_grant  (req_grant),
    .req_done   (req_done),
    .req_error  (req_error),
    .rdata      (rdata),
    .eng_start  (eng_start),
    .eng_write  (eng_write),
    .eng_target (eng_target),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_done   (eng_done),
    .eng_rdata  (eng_rdata),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (eng_start) start_cnt <= start_cnt + 1;
    if (|req_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [1:0] t,
                         input logic [15:0] a, input logic [7:0] d);
    req_write[i]          = w;
    req_target[2*i +: 2]  = t;
    req_addr[16*i +: 16]  = a;
    req_wdata[8*i +: 8]   = d;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_write = '0; req_target = '0;
    req_addr = '0; req_wdata = '0; eng_done = 1'b0; eng_rdata = '0;

    // Reset state
    #23;
    check("rst_grant", req_grant, 0);
    check("rst_done", req_done, 0);
    check("rst_error", req_error, 0);
    check("rst_rdata", rdata, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_addr", eng_addr, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b1;

    // Single read: req0 reads RAM_A @0x1234, engine answers 0x5A
    set_req(0, 1'b0, 2'd1, 16'h1234, 8'h00);
    req_valid = 3'b001;
    tick();
    check("rd_grant", req_grant, 3'b001);
    check("rd_start", eng_start, 1);
    check("rd_addr", eng_addr, 16'h1234);
    check("rd_target", eng_target, 1);
    check("rd_busy", busy, 1);
    tick();
    check("rd_start_once", eng_start, 0);
    check("rd_addr_held", eng_addr, 16'h1234);
    tick(); tick();
    check("rd_no_early_done", req_done, 0);
    eng_done = 1'b1; eng_rdata = 8'h5A;
    tick();
    eng_done = 1'b0; req_valid = 3'b000;
    check("rd_done", req_done, 3'b001);
    check("rd_rdata", rdata, 8'h5A);
    check("rd_error", req_error, 0);
    check("rd_grant_resp", req_grant, 3'b001);
    tick();
    check("rd_done_pulse", req_done, 0);
    check("rd_grant_drop", req_grant, 0);
    check("rd_idle", busy, 0);
    check("rd_eng_clr", eng_addr, 0);
    check("rd_rdata_hold", rdata, 8'h5A);
    check("rd_start_cnt", start_cnt, 1);

    // Write to flash by req1: rejected, no engine activity
    set_req(1, 1'b1, 2'd0, 16'h0010, 8'h99);
    req_valid = 3'b010;
    tick();
    check("fl_grant", req_grant, 3'b010);
    check("fl_no_start", eng_start, 0);
    tick();
    check("fl_done", req_done, 3'b010);
    check("fl_error", req_error, 1);
    check("fl_eng_addr", eng_addr, 0);
    req_valid = 3'b000;
    tick();
    check("fl_idle", busy, 0);
    check("fl_start_cnt", start_cnt, 1);

    // Reset during WAIT of a req2 read (pointer is 2 here)
    set_req(2, 1'b0, 2'd1, 16'h0ABC, 8'h00);
    req_valid = 3'b100;
    tick();
    check("rs_grant", req_grant, 3'b100);
    tick(); tick();
    base = done_cnt;
    reset = 1'b0;
    req_valid = 3'b000;
    #1;
    check("rs_grant_clr", req_grant, 0);
    check("rs_busy_clr", busy, 0);
    check("rs_eng_addr_clr", eng_addr, 0);
    tick();
    check("rs_no_done", done_cnt - base, 0);
    reset = 1'b1;

    // All three request together after reset: order 0,1,2 then req0 again
    set_req(0, 1'b0, 2'd1, 16'h0100, 8'h00);
    set_req(1, 1'b1, 2'd1, 16'h0200, 8'hC3);
    set_req(2, 1'b0, 2'd2, 16'h0300, 8'h00);
    req_valid = 3'b111;
    tick();
    check("rr_first", req_grant, 3'b001);
    check("rr0_addr", eng_addr, 16'h0100);
    tick();
    eng_done = 1'b1; eng_rdata = 8'h10;
    tick();
    eng_done = 1'b0;
    check("rr0_done", req_done, 3'b001);
    check("rr0_rdata", rdata, 8'h10);
    tick();
    set_req(0, 1'b0, 2'd1, 16'h0101, 8'h00);
    tick();
    check("rr_second", req_grant, 3'b010);
    check("rr1_write", eng_write, 1);
    check("rr1_wdata", eng_wdata, 8'hC3);
    check("rr1_addr", eng_addr, 16'h0200);
    tick();
    eng_done = 1'b1; eng_rdata = 8'h77;
    tick();
    eng_done = 1'b0; req_valid[1] = 1'b0;
    check("rr1_done", req_done, 3'b010);
    check("rr1_rdata", rdata, 8'h77);
    check("rr1_error", req_error, 0);
    tick(); tick();
    check("rr_third", req_grant, 3'b100);
    check("rr2_target", eng_target, 2);
    tick();
    eng_done = 1'b1; eng_rdata = 8'h33;
    tick();
    eng_done = 1'b0; req_valid[2] = 1'b0;
    check("rr2_done", req_done, 3'b100);
    tick(); tick();
    check("rr_fourth", req_grant, 3'b001);
    check("rr0b_addr", eng_addr, 16'h0101);
    tick();
    eng_done = 1'b1; eng_rdata = 8'h44;
    tick();
    eng_done = 1'b0; req_valid = 3'b000;
    check("rr0b_done", req_done, 3'b001);
    tick();

    // Reserved target by req2 (pointer is 1): rejected in two cycles
    set_req(2, 1'b0, 2'd3, 16'h0400, 8'h00);
    base = start_cnt;
    req_valid = 3'b100;
    tick();
    check("rsv_grant", req_grant, 3'b100);
    tick();
    check("rsv_done", req_done, 3'b100);
    check("rsv_error", req_error, 1);
    req_valid = 3'b000;
    tick();
    check("rsv_no_start", start_cnt - base, 0);

    // Stray eng_done in IDLE and ISSUE is ignored
    eng_done = 1'b1; eng_rdata = 8'hEE;
    tick();
    check("st_idle_busy", busy, 0);
    check("st_idle_done", req_done, 0);
    check("st_idle_rdata", rdata, 8'h44);
    eng_done = 1'b0;
    set_req(0, 1'b0, 2'd2, 16'h00AA, 8'h00);
    req_valid = 3'b001;
    tick();
    check("st_grant", req_grant, 3'b001);
    eng_done = 1'b1; eng_rdata = 8'h11;
    tick();
    eng_done = 1'b0;
    check("st_issue_done", req_done, 0);
    check("st_issue_busy", busy, 1);
    tick(); tick();
    check("st_wait_done", req_done, 0);
    eng_done = 1'b1; eng_rdata = 8'h22;
    tick();
    eng_done = 1'b0; req_valid = 3'b000;
    check("st_done", req_done, 3'b001);
    check("st_rdata", rdata, 8'h22);
    tick();

    // Engine that never completes (pointer is 1)
    set_req(1, 1'b0, 2'd1, 16'h0F0F, 8'h00);
    req_valid = 3'b010;
    tick();
    tick();
    base = done_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (1022) tick();
    check("to_not_yet", done_cnt - base, 0);
    check("to_busy", busy, 1);
    tick();
    check("to_done", req_done, 3'b010);
    check("to_error", req_error, 1);
    check("to_rdata", rdata, 8'hFF);
    req_valid = 3'b000;
    tick();
    check("to_idle", busy, 0);
`else
    repeat (1100) tick();
    check("nt_no_done", done_cnt - base, 0);
    check("nt_busy", busy, 1);
    eng_done = 1'b1; eng_rdata = 8'h55;
    tick();
    eng_done = 1'b0; req_valid = 3'b000;
    check("nt_done", req_done, 3'b010);
    check("nt_error", req_error, 0);
    check("nt_rdata", rdata, 8'h55);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
